mem_stage_pipe: RTL and testbench

MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

---
 rtl/mem_stage_pipe_if.sv | 23 ++
 rtl/mem_stage_pipe.sv | 160 ++++++++++++++++
 tb/tb_mem_stage_pipe.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pipe_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// A request is held until the slave acknowledges it.
interface mem_stage_pipe_if #(
   parameter int DATA_W = 64
) ();
   logic                  dmem_req;
   logic                  dmem_we;
   logic [DATA_W-1:0]     dmem_addr;
   logic [DATA_W-1:0]     dmem_wdata;
   logic [DATA_W/8-1:0]   dmem_be;
   logic                  dmem_ack;
   logic [DATA_W-1:0]     dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: data-memory access FSM, lane steering/extension, branch resolve, MEM/WB registers.
// Optional access timeout enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage_pipe #(
   parameter int DATA_W   = 64,
   parameter int RD_W     = 5,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              resetl,
   input  logic              valid_mem,
   input  logic              regwrite_mem,
   input  logic              branch_mem,
   input  logic              uncondbranch_mem,
   input  logic              memread_mem,
   input  logic              memwrite_mem,
   input  logic              mem2reg_mem,
   input  logic              signext_mem,
   input  logic              aluzero_mem,
   input  logic [1:0]        size_mem,
   input  logic [RD_W-1:0]   rd_mem,
   input  logic [DATA_W-1:0] regoutb_mem,
   input  logic [DATA_W-1:0] aluout_mem,
   input  logic [DATA_W-1:0] pctarget_mem,
   input  logic [DATA_W-1:0] pc_mem,
   mem_stage_pipe_if.master  dmem,
   output logic              stall_mem,
   output logic              pcsrc,
   output logic              branch_taken_mem,
   output logic [DATA_W-1:0] pctarget,
   output logic [DATA_W-1:0] pc_mem_out,
   output logic              valid_wb,
   output logic              regwrite_wb,
   output logic              mem2reg_wb,
   output logic              mem_fault_wb,
   output logic [RD_W-1:0]   rd_wb,
   output logic [DATA_W-1:0] aluout_wb,
   output logic [DATA_W-1:0] readdata_wb
);
   localparam int NB   = DATA_W / 8;
   localparam int OFFW = $clog2(NB);

   if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
      $error("mem_stage_pipe: DATA_W must be 32 or 64");
   end
   if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_wait
      $error("mem_stage_pipe: MAX_WAIT must be 1..255");
   end

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t              state_q, state_d;
   logic                access;
   logic                timeout;
   logic [1:0]          sz;
   int unsigned         span;
   logic [OFFW-1:0]     offset;
   logic [DATA_W-1:0]   rd_shift, rd_mask, rd_ext;
   logic                rd_sign;

   logic                valid_q, regwrite_q, mem2reg_q;
   logic [RD_W-1:0]     rd_q;
   logic [DATA_W-1:0]   aluout_q, readdata_q;

   assign access = valid_mem & (memread_mem | memwrite_mem);

   // Reset gates the request directly so an in-flight access drops the instant resetl falls.
   assign dmem.dmem_req = resetl & ~timeout & (((state_q == IDLE) & access) | (state_q == ACCESS));
   assign stall_mem     = dmem.dmem_req & ~dmem.dmem_ack;
   assign dmem.dmem_we  = valid_mem & memwrite_mem;

   assign branch_taken_mem = valid_mem & (uncondbranch_mem | (aluzero_mem & branch_mem));
   assign pcsrc            = branch_taken_mem;
   assign pctarget         = pctarget_mem;
   assign pc_mem_out       = pc_mem;

   always_comb begin
      sz        = (DATA_W == 32 && size_mem == 2'd3) ? 2'd2 : size_mem;
      span      = 32'd1 << sz;
      offset    = aluout_mem[OFFW-1:0] & ~OFFW'(span - 32'd1);
      dmem.dmem_addr  = {aluout_mem[DATA_W-1:OFFW], {OFFW{1'b0}}};
      dmem.dmem_be    = NB'((32'd1 << span) - 32'd1) << offset;
      dmem.dmem_wdata = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         dmem.dmem_wdata[8*i +: 8] = regoutb_mem[8*(i % span) +: 8];
      end
      rd_shift = dmem.dmem_rdata >> {offset, 3'b000};
      rd_mask  = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         rd_mask[i] = (i < 8 * span);
      end
      rd_sign = signext_mem & rd_shift[8*span-1];
      rd_ext  = (rd_shift & rd_mask) | ({DATA_W{rd_sign}} & ~rd_mask);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (access && !dmem.dmem_ack) state_d = ACCESS;
         ACCESS: if (dmem.dmem_ack || timeout) state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) state_q <= IDLE;
      else         state_q <= state_d;
   end

`ifdef MEM_STAGE_TIMEOUT_EN
   logic [7:0] wait_q, wait_d;
   logic       fault_q, fault_d;

   // Counter holds the number of stalled cycles; the abort cycle itself does not stall.
   assign timeout = (state_q == ACCESS) && (wait_q == 8'(MAX_WAIT));
   assign wait_d  = stall_mem ? wait_q + 8'd1 : '0;
   assign fault_d = ~stall_mem & timeout;

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         wait_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         wait_q  <= wait_d;
         fault_q <= fault_d;
      end
   end
   assign mem_fault_wb = fault_q;
`else
   assign timeout      = 1'b0;
   assign mem_fault_wb = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         mem2reg_q  <= 1'b0;
         rd_q       <= '0;
         aluout_q   <= '0;
         readdata_q <= '0;
      end else if (stall_mem) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         mem2reg_q  <= 1'b0;
      end else begin
         valid_q    <= valid_mem;
         regwrite_q <= valid_mem & regwrite_mem & ~timeout;
         mem2reg_q  <= mem2reg_mem;
         rd_q       <= rd_mem;
         aluout_q   <= aluout_mem;
         readdata_q <= rd_ext;
      end
   end

   assign valid_wb    = valid_q;
   assign regwrite_wb = regwrite_q;
   assign mem2reg_wb  = mem2reg_q;
   assign rd_wb       = rd_q;
   assign aluout_wb   = aluout_q;
   assign readdata_wb = readdata_q;
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: directed literal cases plus randomized traffic against a behavioural model.
module tb_mem_stage_pipe;
   localparam int DW = 64;
   localparam int RW = 5;
   localparam int MW = 4;

   logic clk = 1'b0;
   logic resetl;
   logic valid_mem, regwrite_mem, branch_mem, uncondbranch_mem, memread_mem;
   logic memwrite_mem, mem2reg_mem, signext_mem, aluzero_mem;
   logic [1:0]    size_mem;
   logic [RW-1:0] rd_mem;
   logic [DW-1:0] regoutb_mem, aluout_mem, pctarget_mem, pc_mem;
   logic          stall_mem, pcsrc, branch_taken_mem;
   logic [DW-1:0] pctarget, pc_mem_out;
   logic          valid_wb, regwrite_wb, mem2reg_wb, mem_fault_wb;
   logic [RW-1:0] rd_wb;
   logic [DW-1:0] aluout_wb, readdata_wb;

   int total = 0;
   int bad   = 0;
   int stalls;

   mem_stage_pipe_if #(.DATA_W(DW)) bus ();

   mem_stage_pipe #(.DATA_W(DW), .RD_W(RW), .MAX_WAIT(MW)) dut (
      .clk(clk), .resetl(resetl),
      .valid_mem(valid_mem), .regwrite_mem(regwrite_mem), .branch_mem(branch_mem),
      .uncondbranch_mem(uncondbranch_mem), .memread_mem(memread_mem),
      .memwrite_mem(memwrite_mem), .mem2reg_mem(mem2reg_mem), .signext_mem(signext_mem),
      .aluzero_mem(aluzero_mem), .size_mem(size_mem), .rd_mem(rd_mem),
      .regoutb_mem(regoutb_mem), .aluout_mem(aluout_mem), .pctarget_mem(pctarget_mem),
      .pc_mem(pc_mem), .dmem(bus), .stall_mem(stall_mem), .pcsrc(pcsrc),
      .branch_taken_mem(branch_taken_mem), .pctarget(pctarget), .pc_mem_out(pc_mem_out),
      .valid_wb(valid_wb), .regwrite_wb(regwrite_wb), .mem2reg_wb(mem2reg_wb),
      .mem_fault_wb(mem_fault_wb), .rd_wb(rd_wb), .aluout_wb(aluout_wb),
      .readdata_wb(readdata_wb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference behaviour of the lane rules, in plain arithmetic.
   function automatic logic [7:0] be_f(input logic [63:0] a, input logic [1:0] s);
      int unsigned sp  = 1 << s;
      int unsigned off = (a % 8) / sp * sp;
      return 8'(((1 << sp) - 1) << off);
   endfunction

   function automatic logic [63:0] wdata_f(input logic [63:0] b, input logic [1:0] s);
      int unsigned sp = 1 << s;
      logic [63:0] w = '0;
      for (int i = 0; i < 8; i++) w[8*i +: 8] = b[8*(i % sp) +: 8];
      return w;
   endfunction

   function automatic logic [63:0] read_f(input logic [63:0] r, input logic [63:0] a,
                                          input logic [1:0] s, input logic sx);
      int unsigned sp  = 1 << s;
      int unsigned off = (a % 8) / sp * sp;
      logic [63:0] v    = r >> (8 * off);
      logic [63:0] mask = (sp < 8) ? (64'd1 << (8 * sp)) - 64'd1 : '1;
      v = v & mask;
      if (sx && v[8*sp-1]) v = v | ~mask;
      return v;
   endfunction

   // Model: m_out marks a request issued but not yet acknowledged.
   logic          m_out = 1'b0;
   logic          e_valid = 1'b0, e_rw = 1'b0, e_m2r = 1'b0, e_fault = 1'b0;
   logic [RW-1:0] e_rd = '0;
   logic [DW-1:0] e_alu = '0, e_rdata = '0;
   logic          m_acc, m_abort, m_req, m_stall, m_br;

   assign m_acc = valid_mem & (memread_mem | memwrite_mem);
`ifdef MEM_STAGE_TIMEOUT_EN
   logic [7:0] m_cnt = '0;
   assign m_abort = m_out && (m_cnt == 8'(MW));
   always @(posedge clk or negedge resetl) begin
      if (!resetl) m_cnt <= '0;
      else         m_cnt <= m_stall ? m_cnt + 8'd1 : '0;
   end
`else
   assign m_abort = 1'b0;
`endif
   assign m_req   = resetl & (m_acc | m_out) & ~m_abort;
   assign m_stall = m_req & ~bus.dmem_ack;
   assign m_br    = valid_mem & (uncondbranch_mem | (aluzero_mem & branch_mem));

   always @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         m_out <= 1'b0; e_valid <= 1'b0; e_rw <= 1'b0; e_m2r <= 1'b0; e_fault <= 1'b0;
         e_rd <= '0; e_alu <= '0; e_rdata <= '0;
      end else begin
         m_out <= m_stall;
         if (m_stall) begin
            e_valid <= 1'b0; e_rw <= 1'b0; e_m2r <= 1'b0; e_fault <= 1'b0;
         end else begin
            e_valid <= valid_mem;
            e_rw    <= valid_mem & regwrite_mem & ~m_abort;
            e_m2r   <= mem2reg_mem;
            e_fault <= m_abort;
            e_rd    <= rd_mem;
            e_alu   <= aluout_mem;
            e_rdata <= read_f(bus.dmem_rdata, aluout_mem, size_mem, signext_mem);
         end
      end
   end

   always @(negedge clk) begin
      chk("req", 64'(bus.dmem_req), 64'(m_req));
      chk("stall", 64'(stall_mem), 64'(m_stall));
      chk("pcsrc", 64'(pcsrc), 64'(m_br));
      chk("taken", 64'(branch_taken_mem), 64'(m_br));
      chk("pctarget", pctarget, pctarget_mem);
      chk("pc_out", pc_mem_out, pc_mem);
      if (m_req) begin
         chk("addr", bus.dmem_addr, {aluout_mem[63:3], 3'b000});
         chk("be", 64'(bus.dmem_be), 64'(be_f(aluout_mem, size_mem)));
         chk("we", 64'(bus.dmem_we), 64'(memwrite_mem));
         if (memwrite_mem) chk("wdata", bus.dmem_wdata, wdata_f(regoutb_mem, size_mem));
      end
      chk("valid_wb", 64'(valid_wb), 64'(e_valid));
      chk("regwrite_wb", 64'(regwrite_wb), 64'(e_rw));
      chk("mem2reg_wb", 64'(mem2reg_wb), 64'(e_m2r));
      chk("fault_wb", 64'(mem_fault_wb), 64'(e_fault));
      chk("rd_wb", 64'(rd_wb), 64'(e_rd));
      chk("aluout_wb", aluout_wb, e_alu);
      chk("readdata_wb", readdata_wb, e_rdata);
   end

   task automatic idle_inputs();
      valid_mem = 0; regwrite_mem = 0; branch_mem = 0; uncondbranch_mem = 0;
      memread_mem = 0; memwrite_mem = 0; mem2reg_mem = 0; signext_mem = 0; aluzero_mem = 0;
      size_mem = '0; rd_mem = '0; regoutb_mem = '0; aluout_mem = '0;
      pctarget_mem = '0; pc_mem = '0; bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
   endtask

   // Entered and left at 1 time unit after a rising edge; holds inputs while the access waits.
   task automatic run_instr();
      int unsigned w, cnt;
      logic acc;
      valid_mem = ($urandom_range(0, 9) != 0);
      regwrite_mem = 1'($urandom); branch_mem = 1'($urandom); uncondbranch_mem = ($urandom_range(0, 7) == 0);
      memread_mem = 1'($urandom); memwrite_mem = 1'($urandom); mem2reg_mem = 1'($urandom);
      signext_mem = 1'($urandom); aluzero_mem = 1'($urandom); size_mem = 2'($urandom);
      rd_mem = RW'($urandom); regoutb_mem = {$urandom, $urandom}; aluout_mem = {$urandom, $urandom};
      pctarget_mem = {$urandom, $urandom}; pc_mem = {$urandom, $urandom};
      acc = valid_mem & (memread_mem | memwrite_mem);
      w = $urandom_range(0, 3);
      cnt = 0;
      bus.dmem_rdata = {$urandom, $urandom};
      bus.dmem_ack = acc ? (w == 0) : 1'($urandom);
      while (1) begin
         @(posedge clk); #1;
         if (!acc || cnt == w) break;
         cnt++;
         bus.dmem_ack = (cnt == w);
         bus.dmem_rdata = {$urandom, $urandom};
      end
   endtask

   initial begin
      resetl = 1'b1;
      idle_inputs();
      #1 resetl = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_valid_wb", 64'(valid_wb), 64'd0);
      chk("rst_readdata_wb", readdata_wb, 64'd0);
      chk("rst_req", 64'(bus.dmem_req), 64'd0);
      @(posedge clk); #1;
      resetl = 1'b1;

      // Zero-wait sign-extended byte load.
      valid_mem = 1; memread_mem = 1; regwrite_mem = 1; mem2reg_mem = 1; size_mem = 2'd0;
      signext_mem = 1; aluout_mem = 64'h1003; rd_mem = 5'd7;
      bus.dmem_rdata = 64'h0000_0000_8000_0000; bus.dmem_ack = 1'b1;
      #1;
      chk("ld_be", 64'(bus.dmem_be), 64'h08);
      chk("ld_addr", bus.dmem_addr, 64'h1000);
      chk("ld_stall", 64'(stall_mem), 64'd0);
      @(posedge clk); #1;
      idle_inputs();
      #1;
      chk("ld_readdata", readdata_wb, 64'hFFFF_FFFF_FFFF_FF80);
      chk("ld_valid", 64'(valid_wb), 64'd1);
      chk("ld_rd", 64'(rd_wb), 64'd7);
      @(posedge clk); #1;

      // Half-word store acknowledged after three wait cycles.
      valid_mem = 1; memwrite_mem = 1; size_mem = 2'd1; aluout_mem = 64'h2006;
      regoutb_mem = 64'h0000_0000_0000_BEEF;
      stalls = 0;
      for (int c = 0; c < 4; c++) begin
         bus.dmem_ack = (c == 3);
         #1;
         if (c == 0) begin
            chk("st_be", 64'(bus.dmem_be), 64'hC0);
            chk("st_wdata", bus.dmem_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
         end
         if (stall_mem) stalls++;
         @(posedge clk); #1;
         if (c < 3) chk("st_bubble", 64'(valid_wb), 64'd0);
         else       chk("st_valid", 64'(valid_wb), 64'd1);
      end
      chk("st_stalls", 64'(stalls), 64'd3);
      idle_inputs();

      // Branch resolution, valid then invalid.
      valid_mem = 1; branch_mem = 1; aluzero_mem = 1; pctarget_mem = 64'h4000;
      #1;
      chk("br_pcsrc", 64'(pcsrc), 64'd1);
      chk("br_target", pctarget, 64'h4000);
      valid_mem = 0;
      #1;
      chk("br_inv_pcsrc", 64'(pcsrc), 64'd0);
      @(posedge clk); #1;
      idle_inputs();

      // Reset in the second ACCESS cycle of a pending load.
      valid_mem = 1; memread_mem = 1; regwrite_mem = 1; aluout_mem = 64'h5008; size_mem = 2'd3;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_req", 64'(bus.dmem_req), 64'd1);
      resetl = 1'b0;
      #1;
      chk("rst_req_drop", 64'(bus.dmem_req), 64'd0);
      chk("rst_stall", 64'(stall_mem), 64'd0);
      chk("rst_wb_valid", 64'(valid_wb), 64'd0);
      chk("rst_wb_aluout", aluout_wb, 64'd0);
      idle_inputs();
      @(posedge clk); #1;
      resetl = 1'b1;
      #1;
      chk("post_rst_idle", 64'(bus.dmem_req), 64'd0);
      @(posedge clk); #1;

      for (int n = 0; n < 300; n++) run_instr();
      idle_inputs();
      @(posedge clk); #1;

`ifdef MEM_STAGE_TIMEOUT_EN
      // Load that is never acknowledged.
      valid_mem = 1; memread_mem = 1; regwrite_mem = 1; aluout_mem = 64'h3000; size_mem = 2'd3;
      stalls = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (!stall_mem) break;
         stalls++;
         @(posedge clk); #1;
      end
      chk("to_stalls", 64'(stalls), 64'd4);
      chk("to_req_drop", 64'(bus.dmem_req), 64'd0);
      @(posedge clk); #1;
      idle_inputs();
      #1;
      chk("to_fault", 64'(mem_fault_wb), 64'd1);
      chk("to_regwrite", 64'(regwrite_wb), 64'd0);
      chk("to_valid", 64'(valid_wb), 64'd1);
      @(posedge clk); #2;
      chk("to_fault_clear", 64'(mem_fault_wb), 64'd0);
      @(posedge clk); #1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
